spi_sclk_gen: RTL
=================

SPI_SCLK_GEN -- requirements
Module: spi_sclk_gen

Interface
REQ-001 Parameter DIV_W, 8, width of the SCLK divisor field.
REQ-002 Parameter CNT_W, 4, width of the bits-per-burst field.
REQ-003 i_clk  input  1  system clock; the block has one clock.
REQ-004 i_rst  input  1  reset, asynchronous and active-high.
REQ-005 i_cfg_valid  input  1  high for one cycle to load i_divisor, i_cpol, i_cpha, i_nbits.
REQ-006 i_divisor  input  DIV_W  SCLK period in i_clk cycles; legal only when even and >= 2.
REQ-007 i_cpol  input  1  SCLK idle level.
REQ-008 i_cpha  input  1  0: sample on leading edge; 1: sample on trailing edge.
REQ-009 i_nbits  input  CNT_W  SCLK cycles per burst; legal only when 1..2^CNT_W-1.
REQ-010 i_start  input  1  high for one cycle to request a burst.
REQ-011 o_ready  output  1  idle and able to accept i_start or i_cfg_valid.
REQ-012 o_sclk  output  1  registered SPI serial clock.
REQ-013 o_sample  output  1  one-cycle strobe at each sample edge.
REQ-014 o_shift  output  1  one-cycle strobe at each shift edge.
REQ-015 o_done  output  1  one-cycle pulse when a burst completes.
REQ-016 o_cfg_err  output  1  one-cycle pulse when a configuration is rejected.

Function
REQ-017 FSM states: IDLE, RUN, TAIL; o_ready=1 only in IDLE.
REQ-018 IDLE, i_cfg_valid=1, all fields legal: fields load; o_sclk takes the new CPOL on the next cycle.
REQ-019 IDLE, i_cfg_valid=1, any field illegal: stored configuration unchanged; o_cfg_err pulses on the next cycle.
REQ-020 i_cfg_valid while not in IDLE: ignored; o_cfg_err pulses on the next cycle.
REQ-021 IDLE, i_start=1 at edge T, i_cfg_valid=0: RUN from T+1; o_ready=0 and o_sclk=CPOL at T+1.
REQ-022 i_cfg_valid and i_start high in the same IDLE cycle: configuration handled per REQ-018/019; i_start ignored.
REQ-023 i_start outside IDLE: ignored, no queuing.
REQ-024 RUN: half-period counter counts divisor/2 cycles; o_sclk toggles at each terminal count; first toggle visible at T+1+divisor/2.
REQ-025 Edge strobes are registered and high in the same cycle o_sclk first shows the new level.
REQ-026 CPHA=0: leading edges assert o_sample, trailing edges assert o_shift; CPHA=1: the reverse.
REQ-027 After 2*nbits toggles (o_sclk back at CPOL), move to TAIL; hold divisor/2 cycles with no strobes.
REQ-028 TAIL end: o_done=1 and o_ready=1 in the same cycle; return to IDLE.
REQ-029 Total busy time (o_ready=0): (2*nbits+1)*divisor/2 cycles.
REQ-030 Configuration is stable for a whole burst; no field changes while RUN or TAIL.
REQ-031 All counters unsigned, no wrap inside a legal burst; divisor/2 is a right shift of the stored divisor.

Reset
REQ-032 While i_rst=1: o_ready=1, o_sclk=0, o_sample=0, o_shift=0, o_done=0, o_cfg_err=0, state IDLE.
REQ-033 Reset configuration: divisor=2, cpol=0, cpha=0, nbits=8.
REQ-034 Reset mid-burst aborts immediately with no o_done; the block resumes from REQ-032 values.

Structure
REQ-035 Shared package spi_pkg holds the state enum and the reset-default constants DEF_DIVISOR, DEF_NBITS, DEF_CPOL, DEF_CPHA.
REQ-036 One sub-module, sclk_tick_counter (DIV_W parameter), produces the half-period terminal-count tick; the FSM, edge counting and strobes stay in spi_sclk_gen.

Verification
REQ-037 Reset held 16 cycles, then released -> o_ready=1, o_sclk=0, no strobes, within 1 cycle.
REQ-038 Defaults (div 2, 8 bits, mode 0), i_start pulse -> 8 SCLK cycles, 8 o_sample on rising edges, 8 o_shift on falling edges, o_done at start+17, o_ready=0 for exactly 17 cycles.
REQ-039 Config div 4, nbits 3, cpol 1, cpha 1, then start -> o_sclk idles high, 6 toggles 2 cycles apart, o_shift on falling and o_sample on rising edges, busy 14 cycles.
REQ-040 Config div 3, then config nbits 0, then config while busy -> o_cfg_err pulses each time; the stored configuration stays unchanged.
REQ-041 i_cfg_valid and i_start together in IDLE -> new configuration loaded, no burst; second start mid-burst -> ignored, single o_done.
REQ-042 i_rst asserted at the 5th SCLK edge of a div 8 burst -> outputs take REQ-032 values asynchronously, no o_done, the next start runs a full burst.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and reset-default configuration for the SPI clock generator.
package spi_pkg;

  // Burst sequencer states: IDLE waits for work, RUN drives SCLK edges,
  // TAIL holds the line idle for one half period before signalling done.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TAIL = 2'd2
  } state_t;

  // Configuration loaded on reset.
  localparam int unsigned DEF_DIVISOR = 2;
  localparam int unsigned DEF_NBITS   = 8;
  localparam logic        DEF_CPOL    = 1'b0;
  localparam logic        DEF_CPHA    = 1'b0;

endpackage

// File: rtl/sclk_tick_counter.sv
// Half-period counter: raises o_tick in the last cycle of every i_half-cycle
// window while enabled. Cleared while the sequencer is idle so each burst
// starts its first half period from zero.
module sclk_tick_counter #(
  parameter int DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_half,
  output logic             o_tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic             last;

  // Terminal-count detect and next count value.
  always_comb begin
    last   = (cnt_q == (i_half - ONE));
    o_tick = i_en && last;
    cnt_d  = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = last ? '0 : (cnt_q + ONE);
    end
  end

  // Count register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: produces a registered SCLK burst of nbits
// cycles with CPOL/CPHA-dependent sample and shift strobes, followed by a
// half-period tail and a done pulse.
//
// Handshake: i_start and i_cfg_valid are single-cycle requests. They are
// acted on only in a cycle where o_ready=1 (IDLE); i_cfg_valid takes
// priority over i_start in the same cycle. Requests while o_ready=0 are
// dropped (a configuration request is additionally flagged on o_cfg_err).
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cfg_valid,
  input  logic [DIV_W-1:0] i_divisor,
  input  logic             i_cpol,
  input  logic             i_cpha,
  input  logic [CNT_W-1:0] i_nbits,
  input  logic             i_start,
  output logic             o_ready,
  output logic             o_sclk,
  output logic             o_sample,
  output logic             o_shift,
  output logic             o_done,
  output logic             o_cfg_err,
  output state_t           o_state
);

  localparam logic [CNT_W:0] ONE_E = (CNT_W+1)'(1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic [CNT_W:0]   edge_q, edge_d;
  logic             sclk_q, sclk_d;
  logic             sample_q, sample_d;
  logic             shift_q, shift_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;
  logic             ready_q, ready_d;

  logic [DIV_W-1:0] half;
  logic [CNT_W:0]   edge_last;
  logic             cfg_legal;
  logic             tick;

  // Half period is the stored divisor shifted right; the last edge index
  // of a burst is 2*nbits-1.
  always_comb begin
    half      = {1'b0, div_q[DIV_W-1:1]};
    edge_last = {nbits_q, 1'b0} - ONE_E;
    cfg_legal = !i_divisor[0] && (i_divisor != '0) && (i_nbits != '0);
  end

  sclk_tick_counter #(
    .DIV_W(DIV_W)
  ) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (state_q == ST_IDLE),
    .i_en   (state_q != ST_IDLE),
    .i_half (half),
    .o_tick (tick)
  );

  // Next-state and registered-output logic for the burst sequencer.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    nbits_d   = nbits_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    edge_d    = edge_q;
    sclk_d    = sclk_q;
    sample_d  = 1'b0;
    shift_d   = 1'b0;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_cfg_valid) begin
          if (cfg_legal) begin
            div_d   = i_divisor;
            nbits_d = i_nbits;
            cpol_d  = i_cpol;
            cpha_d  = i_cpha;
            sclk_d  = i_cpol;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else if (i_start) begin
          state_d = ST_RUN;
          edge_d  = '0;
          sclk_d  = cpol_q;
        end
      end
      ST_RUN: begin
        cfg_err_d = i_cfg_valid;
        if (tick) begin
          sclk_d   = ~sclk_q;
          edge_d   = edge_q + ONE_E;
          // Even edge index = leading edge. Sample on leading when CPHA=0,
          // on trailing when CPHA=1; shift on the other one.
          sample_d = (edge_q[0] == cpha_q);
          shift_d  = (edge_q[0] != cpha_q);
          if (edge_q == edge_last) begin
            state_d = ST_TAIL;
          end
        end
      end
      ST_TAIL: begin
        cfg_err_d = i_cfg_valid;
        if (tick) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sclk_d  = cpol_q;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // State, configuration and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      div_q     <= DIV_W'(DEF_DIVISOR);
      nbits_q   <= CNT_W'(DEF_NBITS);
      cpol_q    <= DEF_CPOL;
      cpha_q    <= DEF_CPHA;
      edge_q    <= '0;
      sclk_q    <= 1'b0;
      sample_q  <= 1'b0;
      shift_q   <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      nbits_q   <= nbits_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      edge_q    <= edge_d;
      sclk_q    <= sclk_d;
      sample_q  <= sample_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      ready_q   <= ready_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_sclk    = sclk_q;
  assign o_sample  = sample_q;
  assign o_shift   = shift_q;
  assign o_done    = done_q;
  assign o_cfg_err = cfg_err_q;
  assign o_state   = state_q;

endmodule
